// File: rtl/ide_cycle_ctrl_if.sv
// Bus bundle between the 68030-side decode/handshake and the IDE PIO port.
// master = CPU/IDE environment driving requests, slave = the cycle controller.
interface ide_cycle_ctrl_if;
    logic        as20;
    logic        ds20;
    logic        rw;
    logic [31:0] a;
    logic        iordy;
    logic        ide_cs0_n;
    logic        ide_cs1_n;
    logic [2:0]  ide_a;
    logic        ide_rd_n;
    logic        ide_wr_n;
    logic        buf_oe_n;
    logic        buf_dir;
    logic [1:0]  dsack_n;
    logic        access;
    logic        busy;

    modport master (
        output as20, ds20, rw, a, iordy,
        input  ide_cs0_n, ide_cs1_n, ide_a, ide_rd_n, ide_wr_n,
               buf_oe_n, buf_dir, dsack_n, access, busy
    );

    modport slave (
        input  as20, ds20, rw, a, iordy,
        output ide_cs0_n, ide_cs1_n, ide_a, ide_rd_n, ide_wr_n,
               buf_oe_n, buf_dir, dsack_n, access, busy
    );
endinterface

// File: rtl/ide_cycle_ctrl.sv
// PIO cycle sequencer for the $DA2000-$DA3FFF IDE window: chip selects, strobes,
// buffer control with setup/strobe/hold timing, terminated as a 16-bit port.
module ide_cycle_ctrl #(
    parameter int SETUP_CYC   = 2,
    parameter int STROBE_CYC  = 6,
    parameter int HOLD_CYC    = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic            CLKCPU,
    input  logic            RESET,
    ide_cycle_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, ACK, HOLD} state_t;

    localparam logic [3:0] SETUP_L  = 4'(SETUP_CYC);
    localparam logic [3:0] STROBE_L = 4'(STROBE_CYC);
    localparam logic [3:0] HOLD_L   = 4'(HOLD_CYC);
    localparam logic [7:0] TMO_L    = 8'(TIMEOUT_CYC);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] tmo_q, tmo_d;
    logic [1:0] iordy_sync_q;
    logic       cs0_n_q, cs0_n_d, cs1_n_q, cs1_n_d;
    logic       rd_n_q, rd_n_d, wr_n_q, wr_n_d;
    logic       oe_n_q, oe_n_d, dir_q, dir_d, busy_q;
    logic [2:0] ide_a_q, ide_a_d;
    logic [1:0] dsack_n_q, dsack_n_d;
    logic       hit, enter_hold, unused_addr_bits;

    assign hit              = (bus.a[31:13] == {16'h00DA, 3'b001});
    assign unused_addr_bits = ^{bus.a[11:5], bus.a[1:0]};

    assign bus.access    = ~hit;
    assign bus.ide_cs0_n = cs0_n_q;
    assign bus.ide_cs1_n = cs1_n_q;
    assign bus.ide_a     = ide_a_q;
    assign bus.ide_rd_n  = rd_n_q;
    assign bus.ide_wr_n  = wr_n_q;
    assign bus.buf_oe_n  = oe_n_q;
    assign bus.buf_dir   = dir_q;
    assign bus.dsack_n   = dsack_n_q;
    assign bus.busy      = busy_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
        cs0_n_d    = cs0_n_q;
        cs1_n_d    = cs1_n_q;
        rd_n_d     = rd_n_q;
        wr_n_d     = wr_n_q;
        oe_n_d     = oe_n_q;
        dir_d      = dir_q;
        ide_a_d    = ide_a_q;
        dsack_n_d  = dsack_n_q;
        enter_hold = 1'b0;

        case (state_q)
            IDLE: begin
                if (!bus.as20 && hit) begin
                    state_d = SETUP;
                    cs0_n_d = bus.a[12];
                    cs1_n_d = ~bus.a[12];
                    ide_a_d = bus.a[4:2];
                    dir_d   = ~bus.rw;
                    oe_n_d  = 1'b0;
                    cnt_d   = SETUP_L;
                end
            end
            SETUP: begin
                if (bus.as20) begin
                    enter_hold = 1'b1;
                end else if (cnt_q <= 4'd1) begin
                    state_d = STROBE;
                    cnt_d   = STROBE_L;
                    tmo_d   = TMO_L;
                    if (!dir_q)
                        rd_n_d = 1'b0;
                    else if (!bus.ds20)
                        wr_n_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            STROBE: begin
                if (bus.as20) begin
                    enter_hold = 1'b1;
                end else if (rd_n_q && wr_n_q) begin
                    // Write entered before DS20: strobe timing starts once data is valid
                    if (!bus.ds20)
                        wr_n_d = 1'b0;
                end else if (cnt_q > 4'd1) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    cnt_d = 4'd0;
                    if (iordy_sync_q[1] || (cnt_q == 4'd0 && tmo_q <= 8'd1)) begin
                        state_d   = ACK;
                        dsack_n_d = 2'b01;
                    end else if (cnt_q == 4'd0) begin
                        tmo_d = tmo_q - 8'd1;
                    end
                end
            end
            ACK: begin
                if (bus.as20)
                    enter_hold = 1'b1;
            end
            HOLD: begin
                if (cnt_q <= 4'd1) begin
                    state_d = IDLE;
                    cs0_n_d = 1'b1;
                    cs1_n_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (enter_hold) begin
            state_d   = HOLD;
            rd_n_d    = 1'b1;
            wr_n_d    = 1'b1;
            oe_n_d    = 1'b1;
            dsack_n_d = 2'b11;
            cnt_d     = HOLD_L;
        end
    end

    always_ff @(posedge CLKCPU or negedge RESET) begin
        if (!RESET) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            tmo_q        <= 8'd0;
            iordy_sync_q <= 2'b00;
            cs0_n_q      <= 1'b1;
            cs1_n_q      <= 1'b1;
            rd_n_q       <= 1'b1;
            wr_n_q       <= 1'b1;
            oe_n_q       <= 1'b1;
            dir_q        <= 1'b0;
            ide_a_q      <= 3'd0;
            dsack_n_q    <= 2'b11;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tmo_q        <= tmo_d;
            iordy_sync_q <= {iordy_sync_q[0], bus.iordy};
            cs0_n_q      <= cs0_n_d;
            cs1_n_q      <= cs1_n_d;
            rd_n_q       <= rd_n_d;
            wr_n_q       <= wr_n_d;
            oe_n_q       <= oe_n_d;
            dir_q        <= dir_d;
            ide_a_q      <= ide_a_d;
            dsack_n_q    <= dsack_n_d;
            busy_q       <= (state_d != IDLE);
        end
    end
endmodule
